bayer_packer: RTL

- Reverse direction of the pixel debayer path: accepts one 32-bit ARGB pixel per handshake and serializes it into four 8-bit Bayer intensity samples, in order R, G1, G2, B.
- Sits between the frame source and the sensor-side, byte-wide intensity interface (sensor emulation and round-trip test path).
- Green is replicated, G1 = G2 = G, so averaging G1 and G2 on the receive side reproduces G exactly.
- Also tracks a pixel count per frame and a sticky flag for non-opaque alpha.

---
 rtl/bayer_packer.sv | 116 +++++++++++
 1 files changed

// File: rtl/bayer_packer.sv
// Serializes one ARGB pixel into four byte-wide Bayer samples (R, G1, G2, B),
// tracking a per-frame pixel count and a sticky non-opaque alpha flag.
//
// state | meaning
// IDLE  | no pixel held, ready to accept
// S_R   | presenting R of the held pixel
// S_G1  | presenting G as G1
// S_G2  | presenting G as G2
// S_B   | presenting B; may accept the next pixel in the same cycle
module bayer_packer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [31:0]        in_argb,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic [7:0]         out_sample,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic [COUNT_W-1:0] pix_count,
    output logic               alpha_err,
    input  logic               clear_err
);

    typedef enum logic [2:0] {IDLE, S_R, S_G1, S_G2, S_B} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] hold_rgb;
    logic        sof_q;
    logic        accept;

    // Accepting in S_B with out_ready lets pixels stream with no idle bubble.
    assign in_ready = (state == IDLE) || ((state == S_B) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            hold_rgb <= '0;
            sof_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_rgb <= in_argb[23:0];
                sof_q    <= in_sof;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = S_R;
            S_R:  if (out_ready) state_nxt = S_G1;
            S_G1: if (out_ready) state_nxt = S_G2;
            S_G2: if (out_ready) state_nxt = S_B;
            S_B:  if (out_ready) state_nxt = accept ? S_R : IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_sample = 8'h00;
        out_sel    = 2'd0;
        case (state)
            S_R: begin
                out_sample = hold_rgb[23:16];
                out_sel    = 2'd0;
            end
            S_G1: begin
                out_sample = hold_rgb[15:8];
                out_sel    = 2'd1;
            end
            S_G2: begin
                out_sample = hold_rgb[15:8];
                out_sel    = 2'd2;
            end
            S_B: begin
                out_sample = hold_rgb[7:0];
                out_sel    = 2'd3;
            end
            default: begin
                out_sample = 8'h00;
                out_sel    = 2'd0;
            end
        endcase
    end

    assign out_valid = (state != IDLE);
    assign out_sof   = sof_q && (state == S_R);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_count <= '0;
        end else if (accept) begin
            pix_count <= in_sof ? COUNT_W'(1) : pix_count + COUNT_W'(1);
        end
    end

    // A set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            alpha_err <= 1'b0;
        end else if (accept && (in_argb[31:24] != 8'hFF)) begin
            alpha_err <= 1'b1;
        end else if (clear_err) begin
            alpha_err <= 1'b0;
        end
    end

endmodule
